// File: rtl/mjpeg_pkg.sv
// Shared MJPEG encoder definitions: scheduler states, component IDs, block geometry
// and the quantisation-table selector codes.
package mjpeg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_GAP  = 2'd3
  } sched_state_t;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_t;

  localparam int         BLK_BEATS  = 64;
  localparam logic [5:0] BEAT_LAST  = 6'(BLK_BEATS - 1);
  localparam logic [5:0] BEAT_PRE   = 6'(BLK_BEATS - 2);
  localparam logic       TBL_LUMA   = 1'b0;
  localparam logic       TBL_CHROMA = 1'b1;

  // MCU order: Y_PER_MCU luma blocks, then one Cb, then one Cr.
  function automatic comp_t comp_of_blk(input logic [2:0] blk_idx, input logic [2:0] y_per_mcu);
    if (blk_idx < y_per_mcu) begin
      return COMP_Y;
    end else if (blk_idx == y_per_mcu) begin
      return COMP_CB;
    end
    return COMP_CR;
  endfunction

  function automatic logic [2:0] comp_onehot(input comp_t c);
    logic [2:0] oh;
    oh = 3'b000;
    case (c)
      COMP_Y:  oh = 3'b001;
      COMP_CB: oh = 3'b010;
      COMP_CR: oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  function automatic comp_t onehot_to_comp(input logic [2:0] oh);
    if (oh[2]) begin
      return COMP_CR;
    end else if (oh[1]) begin
      return COMP_CB;
    end
    return COMP_Y;
  endfunction

  function automatic logic table_of(input comp_t c);
    return (c == COMP_Y) ? TBL_LUMA : TBL_CHROMA;
  endfunction

endpackage

// File: rtl/quant_blk_seq_cnt.sv
// Counter chain for the block scheduler: beat within a block, block within an MCU,
// MCU within a frame, each with a terminal-count flag.
module quant_blk_seq_cnt
  import mjpeg_pkg::*;
#(
  parameter int Y_PER_MCU     = 4,
  parameter int MCU_PER_FRAME = 1200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       clr_all,
  input  logic       beat_inc,
  input  logic       beat_clr,
  input  logic       blk_step,
  output logic [5:0] beat,
  output logic [2:0] blk_idx,
  output logic       beat_last,
  output logic       beat_pre_last,
  output logic       blk_last,
  output logic       mcu_last
);

  localparam logic [2:0]  BLK_LAST = 3'(Y_PER_MCU + 1);
  localparam logic [15:0] MCU_LAST = 16'(MCU_PER_FRAME - 1);

  logic [5:0]  beat_reg;
  logic [2:0]  blk_reg;
  logic [15:0] mcu_reg;

  // The beat counter wraps 63 -> 0 on its own, so it is already 0 in GAP.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      beat_reg <= 6'd0;
    end else if (beat_clr || clr_all) begin
      beat_reg <= 6'd0;
    end else if (beat_inc) begin
      beat_reg <= 6'(beat_reg + 6'd1);
    end
  end

  // On the final block of the final MCU only blk_idx clears; mcu_cnt parks at its terminal value.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      blk_reg <= 3'd0;
      mcu_reg <= 16'd0;
    end else if (clr_all) begin
      blk_reg <= 3'd0;
      mcu_reg <= 16'd0;
    end else if (blk_step) begin
      if (blk_reg == BLK_LAST) begin
        blk_reg <= 3'd0;
        if (mcu_reg != MCU_LAST) begin
          mcu_reg <= 16'(mcu_reg + 16'd1);
        end
      end else begin
        blk_reg <= 3'(blk_reg + 3'd1);
      end
    end
  end

  assign beat          = beat_reg;
  assign blk_idx       = blk_reg;
  assign beat_last     = (beat_reg == BEAT_LAST);
  assign beat_pre_last = (beat_reg == BEAT_PRE);
  assign blk_last      = (blk_reg == BLK_LAST);
  assign mcu_last      = (mcu_reg == MCU_LAST);

endmodule

// File: rtl/quant_block_sched.sv
// Sequences Y/Cb/Cr DCT blocks into the quantiser in MCU order as 64-beat read bursts,
// with a delayed quantiser start, explicit table select and downstream bank backpressure.
module quant_block_sched
  import mjpeg_pkg::*;
#(
  parameter int Y_PER_MCU     = 4,
  parameter int MCU_PER_FRAME = 1200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       frame_start,
  input  logic       frame_abort,
  input  logic [2:0] req,
  input  logic [1:0] bank_busy,
  output logic [2:0] grant,
  output logic       rd_en,
  output logic [5:0] rd_addr,
  output logic [2:0] blk_ack,
  output logic       quant_start,
  output logic       table_sel,
  output logic [1:0] comp_id,
  output logic       mcu_done,
  output logic       frame_done,
  output logic       busy
);

  localparam logic [2:0] Y_N = 3'(Y_PER_MCU);

  sched_state_t state_reg;
  logic         rd_en_reg;
  logic [2:0]   grant_reg;
  logic [2:0]   blk_ack_reg;
  logic         quant_start_reg;
  logic         table_sel_reg;
  logic [1:0]   comp_id_reg;
  logic         mcu_done_reg;
  logic         frame_done_reg;
  logic         busy_reg;

  logic [5:0]   beat;
  logic [2:0]   blk_idx;
  logic         beat_last;
  logic         beat_pre_last;
  logic         blk_last;
  logic         mcu_last;

  comp_t        exp_comp;
  comp_t        next_comp;
  logic         bank_free;
  logic         exp_ready;
  logic         next_ready;

  logic         clr_all;
  logic         beat_inc;
  logic         blk_step;

  // next_comp is the block that follows the one finishing now; GAP samples it so an
  // unstalled stream keeps a 65-cycle block period.
  always_comb begin
    exp_comp   = comp_of_blk(blk_idx, Y_N);
    next_comp  = blk_last ? COMP_Y : comp_of_blk(3'(blk_idx + 3'd1), Y_N);
    bank_free  = (bank_busy != 2'b11);
    exp_ready  = req[exp_comp] && bank_free;
    next_ready = req[next_comp] && bank_free;
  end

  assign clr_all  = (state_reg == ST_IDLE) && frame_start && !frame_abort;
  assign beat_inc = (state_reg == ST_RUN) && !frame_abort;
  assign blk_step = (state_reg == ST_GAP) && !frame_abort;

  quant_blk_seq_cnt #(
    .Y_PER_MCU    (Y_PER_MCU),
    .MCU_PER_FRAME(MCU_PER_FRAME)
  ) u_seq_cnt (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .clr_all      (clr_all),
    .beat_inc     (beat_inc),
    .beat_clr     (frame_abort),
    .blk_step     (blk_step),
    .beat         (beat),
    .blk_idx      (blk_idx),
    .beat_last    (beat_last),
    .beat_pre_last(beat_pre_last),
    .blk_last     (blk_last),
    .mcu_last     (mcu_last)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg       <= ST_IDLE;
      rd_en_reg       <= 1'b0;
      grant_reg       <= 3'b000;
      blk_ack_reg     <= 3'b000;
      quant_start_reg <= 1'b0;
      table_sel_reg   <= TBL_LUMA;
      comp_id_reg     <= 2'd0;
      mcu_done_reg    <= 1'b0;
      frame_done_reg  <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      // Quantiser side trails the read side by the one-cycle buffer read latency.
      quant_start_reg <= rd_en_reg;
      comp_id_reg     <= onehot_to_comp(grant_reg);
      table_sel_reg   <= table_of(onehot_to_comp(grant_reg));
      blk_ack_reg     <= 3'b000;
      mcu_done_reg    <= 1'b0;
      frame_done_reg  <= 1'b0;

      if (frame_abort) begin
        state_reg <= ST_IDLE;
        rd_en_reg <= 1'b0;
        grant_reg <= 3'b000;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (frame_start) begin
              state_reg <= ST_WAIT;
              busy_reg  <= 1'b1;
            end
          end
          ST_WAIT: begin
            if (exp_ready) begin
              state_reg <= ST_RUN;
              rd_en_reg <= 1'b1;
              grant_reg <= comp_onehot(exp_comp);
            end
          end
          ST_RUN: begin
            if (beat_last) begin
              state_reg      <= ST_GAP;
              rd_en_reg      <= 1'b0;
              grant_reg      <= 3'b000;
              mcu_done_reg   <= blk_last;
              frame_done_reg <= blk_last && mcu_last;
            end else if (beat_pre_last) begin
              blk_ack_reg <= grant_reg;
            end
          end
          ST_GAP: begin
            if (blk_last && mcu_last) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end else if (next_ready) begin
              state_reg <= ST_RUN;
              rd_en_reg <= 1'b1;
              grant_reg <= comp_onehot(next_comp);
            end else begin
              state_reg <= ST_WAIT;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign grant       = grant_reg;
  assign rd_en       = rd_en_reg;
  assign rd_addr     = beat;
  assign blk_ack     = blk_ack_reg;
  assign quant_start = quant_start_reg;
  assign table_sel   = table_sel_reg;
  assign comp_id     = comp_id_reg;
  assign mcu_done    = mcu_done_reg;
  assign frame_done  = frame_done_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_quant_block_sched.sv
// Bench for quant_block_sched: a 4:2:0 single-MCU instance (a) and a 4:2:2 three-MCU
// instance (b), checked against closed-form timing and a burst-level random model.
module tb_quant_block_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       rst_n_a, fs_a, fa_a;
  logic [2:0] req_a;
  logic [1:0] bb_a;
  logic [2:0] grant_a, blk_ack_a;
  logic       rd_en_a, quant_start_a, table_sel_a, mcu_done_a, frame_done_a, busy_a;
  logic [5:0] rd_addr_a;
  logic [1:0] comp_id_a;

  logic       rst_n_b, fs_b, fa_b;
  logic [2:0] req_b;
  logic [1:0] bb_b;
  logic [2:0] grant_b, blk_ack_b;
  logic       rd_en_b, quant_start_b, table_sel_b, mcu_done_b, frame_done_b, busy_b;
  logic [5:0] rd_addr_b;
  logic [1:0] comp_id_b;

  quant_block_sched #(.Y_PER_MCU(4), .MCU_PER_FRAME(1)) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n_a), .frame_start(fs_a), .frame_abort(fa_a),
    .req(req_a), .bank_busy(bb_a), .grant(grant_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .blk_ack(blk_ack_a), .quant_start(quant_start_a), .table_sel(table_sel_a),
    .comp_id(comp_id_a), .mcu_done(mcu_done_a), .frame_done(frame_done_a), .busy(busy_a)
  );

  quant_block_sched #(.Y_PER_MCU(2), .MCU_PER_FRAME(3)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n_b), .frame_start(fs_b), .frame_abort(fa_b),
    .req(req_b), .bank_busy(bb_b), .grant(grant_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .blk_ack(blk_ack_b), .quant_start(quant_start_b), .table_sel(table_sel_b),
    .comp_id(comp_id_b), .mcu_done(mcu_done_b), .frame_done(frame_done_b), .busy(busy_b)
  );

  // Packed view: [19:17] grant [16] rd_en [15:10] rd_addr [9:7] blk_ack [6] quant_start
  // [5] table_sel [4:3] comp_id [2] mcu_done [1] frame_done [0] busy
  logic [19:0] obs_a, obs_b;
  assign obs_a = {grant_a, rd_en_a, rd_addr_a, blk_ack_a, quant_start_a, table_sel_a,
                  comp_id_a, mcu_done_a, frame_done_a, busy_a};
  assign obs_b = {grant_b, rd_en_b, rd_addr_b, blk_ack_b, quant_start_b, table_sel_b,
                  comp_id_b, mcu_done_b, frame_done_b, busy_b};

  function automatic int comp_of(int b, int y);
    int bi;
    bi = b % (y + 2);
    if (bi < y) return 0;
    if (bi == y) return 1;
    return 2;
  endfunction

  function automatic logic [19:0] pack(logic [2:0] g, logic rd, logic [5:0] a, logic [2:0] ack,
                                       logic qs, logic ts, logic [1:0] cid, logic md,
                                       logic fd, logic bz);
    return {g, rd, a, ack, qs, ts, cid, md, fd, bz};
  endfunction

  // rd_addr only matters during a read, table_sel/comp_id only while quant_start is high.
  function automatic logic [19:0] care(logic [19:0] e);
    logic [19:0] m;
    m = '1;
    if (!e[16]) m[15:10] = '0;
    if (!e[6]) m[5:3] = '0;
    return m;
  endfunction

  // Unstalled frame: cycle 0 carries frame_start, bursts start at 2 + 65*k.
  function automatic logic [19:0] exp_full(int n, int y, int nblk);
    int m, b, p, c, cq;
    logic rd, qs, md, fd, bz;
    logic [2:0] g, ack;
    logic [5:0] a;
    rd = 0; qs = 0; md = 0; fd = 0; g = 0; ack = 0; a = 0; cq = 0;
    if (n >= 2) begin
      m = n - 2; b = m / 65; p = m % 65;
      if (b < nblk) begin
        c = comp_of(b, y);
        if (p < 64) begin
          rd = 1; g = 3'(1 << c); a = 6'(p);
          if (p == 63) ack = g;
        end else begin
          md = ((b % (y + 2)) == y + 1);
          fd = (b == nblk - 1);
        end
      end
    end
    if (n >= 3) begin
      m = n - 3; b = m / 65; p = m % 65;
      if (b < nblk && p < 64) begin
        qs = 1; cq = comp_of(b, y);
      end
    end
    bz = (n >= 1) && (n <= 1 + nblk * 65);
    return pack(g, rd, a, ack, qs, (cq != 0), 2'(cq), md, fd, bz);
  endfunction

  task automatic test_reset();
    rst_n_a = 0; fs_a = 0; fa_a = 0; req_a = 0; bb_a = 0;
    rst_n_b = 0; fs_b = 0; fa_b = 0; req_b = 0; bb_b = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs_a !== 20'd0) begin errors++; $display("FAIL reset_a: got %h expected 0", obs_a); end
    checks++;
    if (obs_b !== 20'd0) begin errors++; $display("FAIL reset_b: got %h expected 0", obs_b); end
    rst_n_a = 1; rst_n_b = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs_a !== 20'd0) begin errors++; $display("FAIL idle_after_reset_a: got %h expected 0", obs_a); end
  endtask

  task automatic test_single_mcu();
    logic [19:0] e, m;
    int bursts;
    logic prev;
    bursts = 0; prev = 0;
    req_a = 3'b111; bb_a = 2'b00; fs_a = 1;
    @(negedge clk);
    fs_a = 0;
    for (int n = 1; n <= 395; n++) begin
      e = exp_full(n, 4, 6); m = care(e);
      checks++;
      if ((obs_a & m) !== (e & m)) begin
        errors++; $display("FAIL single_mcu cycle %0d: got %h expected %h", n, obs_a & m, e & m);
      end
      if (rd_en_a && !prev) bursts++;
      prev = rd_en_a;
      @(negedge clk);
    end
    checks++;
    if (bursts != 6) begin errors++; $display("FAIL single_mcu_bursts: got %0d expected 6", bursts); end
  endtask

  task automatic test_order();
    req_a = 3'b110; bb_a = 2'b00; fs_a = 1;
    @(negedge clk);
    fs_a = 0;
    for (int n = 1; n <= 10; n++) begin
      checks++;
      if ({grant_a, rd_en_a, busy_a} !== 5'b00001) begin
        errors++; $display("FAIL order_hold cycle %0d: got %b expected 00001", n, {grant_a, rd_en_a, busy_a});
      end
      if (n == 10) req_a = 3'b111;
      @(negedge clk);
    end
    checks++;
    if ({grant_a, rd_en_a, rd_addr_a} !== {3'b001, 1'b1, 6'd0}) begin
      errors++; $display("FAIL order_release: got %b expected 0011000000", {grant_a, rd_en_a, rd_addr_a});
    end
    fa_a = 1; @(negedge clk); fa_a = 0; @(negedge clk);
    checks++;
    if ({busy_a, rd_en_a, quant_start_a} !== 3'b000) begin
      errors++; $display("FAIL order_abort: got %b expected 000", {busy_a, rd_en_a, quant_start_a});
    end
  endtask

  task automatic test_backpressure();
    req_a = 3'b111; bb_a = 2'b11; fs_a = 1;
    @(negedge clk);
    fs_a = 0;
    for (int n = 1; n <= 10; n++) begin
      checks++;
      if ({rd_en_a, busy_a} !== 2'b01) begin
        errors++; $display("FAIL bp_stall cycle %0d: got %b expected 01", n, {rd_en_a, busy_a});
      end
      if (n == 10) bb_a = 2'b01;
      @(negedge clk);
    end
    checks++;
    if ({grant_a, rd_en_a, rd_addr_a} !== {3'b001, 1'b1, 6'd0}) begin
      errors++; $display("FAIL bp_release: got %b expected 0011000000", {grant_a, rd_en_a, rd_addr_a});
    end
    fa_a = 1; @(negedge clk); fa_a = 0; repeat (2) @(negedge clk);
    bb_a = 2'b00;
  endtask

  task automatic test_abort();
    logic [19:0] e, m;
    int pulses;
    pulses = 0;
    req_a = 3'b111; bb_a = 2'b00; fs_a = 1;
    @(negedge clk);
    fs_a = 0;
    for (int n = 1; n <= 292; n++) begin
      e = exp_full(n, 4, 6); m = care(e);
      checks++;
      if ((obs_a & m) !== (e & m)) begin
        errors++; $display("FAIL abort_pre cycle %0d: got %h expected %h", n, obs_a & m, e & m);
      end
      if (n == 292) fa_a = 1;
      @(negedge clk);
    end
    fa_a = 0;
    checks++;
    if ({rd_en_a, grant_a, blk_ack_a, busy_a, quant_start_a} !== 9'b000000001) begin
      errors++; $display("FAIL abort_next: got %b expected 000000001",
                         {rd_en_a, grant_a, blk_ack_a, busy_a, quant_start_a});
    end
    @(negedge clk);
    checks++;
    if (quant_start_a !== 1'b0) begin errors++; $display("FAIL abort_qs: got %b expected 0", quant_start_a); end
    for (int n = 0; n < 70; n++) begin
      if (rd_en_a || busy_a || (blk_ack_a != 0) || mcu_done_a || frame_done_a) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", pulses); end
  endtask

  task automatic test_start_abort();
    req_a = 3'b111; fs_a = 1; fa_a = 1;
    @(negedge clk);
    fs_a = 0; fa_a = 0;
    for (int n = 0; n < 4; n++) begin
      checks++;
      if ({busy_a, rd_en_a} !== 2'b00) begin
        errors++; $display("FAIL start_abort cycle %0d: got %b expected 00", n, {busy_a, rd_en_a});
      end
      @(negedge clk);
    end
  endtask

  // Burst-level model: a burst starts the cycle after the next block's requester and a
  // free bank are both seen outside a burst; the cycle after a burst is its gap.
  task automatic test_random();
    int pos, s, sample_from, last_gap, n, c, cq_prev;
    logic rd, prev_rd, md, fd, bz;
    logic [2:0] g, ack, drop;
    logic [5:0] a;
    logic [19:0] e, m;
    pos = 0; s = -1000; sample_from = 1; last_gap = -1; prev_rd = 0; cq_prev = 0; drop = 0;
    req_a = 3'($urandom_range(0, 7)); bb_a = 2'b00; fs_a = 1;
    @(negedge clk);
    fs_a = 0;
    n = 1;
    while (n < 3000 && !(last_gap >= 0 && n > last_gap + 3)) begin
      rd = (n >= s) && (n <= s + 63);
      c = (pos < 6) ? comp_of(pos, 4) : 0;
      g = rd ? 3'(1 << c) : 3'b000;
      a = rd ? 6'(n - s) : 6'd0;
      ack = (rd && n == s + 63) ? g : 3'b000;
      md = 0; fd = 0;
      if (n == s + 64) begin
        md = ((pos % 6) == 5);
        fd = (pos == 5);
        if (fd) last_gap = n;
        pos++;
        sample_from = n;
      end
      bz = (last_gap < 0) || (n <= last_gap);
      e = pack(g, rd, a, ack, prev_rd, (cq_prev != 0), 2'(cq_prev), md, fd, bz);
      m = care(e);
      checks++;
      if ((obs_a & m) !== (e & m)) begin
        errors++; $display("FAIL random cycle %0d: got %h expected %h", n, obs_a & m, e & m);
      end
      prev_rd = rd;
      if (rd) cq_prev = c;
      req_a = req_a & ~drop;
      drop = ack;
      for (int k = 0; k < 3; k++) if ($urandom_range(0, 7) == 0) req_a[k] = 1'b1;
      bb_a = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if (!rd && pos < 6 && n >= sample_from && req_a[comp_of(pos, 4)] && bb_a != 2'b11) s = n + 1;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin errors++; $display("FAIL random_timeout: got %0d cycles expected < 3000", n); end
    bb_a = 2'b00;
  endtask

  task automatic test_multi_mcu();
    logic [19:0] e, m;
    int bursts, mds, fds;
    logic prev;
    bursts = 0; mds = 0; fds = 0; prev = 0;
    req_b = 3'b111; bb_b = 2'b00; fs_b = 1;
    @(negedge clk);
    fs_b = 0;
    repeat (299) @(negedge clk);
    fa_b = 1; @(negedge clk); fa_b = 0; repeat (2) @(negedge clk);
    checks++;
    if ({busy_b, rd_en_b, quant_start_b} !== 3'b000) begin
      errors++; $display("FAIL multi_abort: got %b expected 000", {busy_b, rd_en_b, quant_start_b});
    end
    fs_b = 1;
    @(negedge clk);
    fs_b = 0;
    for (int n = 1; n <= 785; n++) begin
      e = exp_full(n, 2, 12); m = care(e);
      checks++;
      if ((obs_b & m) !== (e & m)) begin
        errors++; $display("FAIL multi_mcu cycle %0d: got %h expected %h", n, obs_b & m, e & m);
      end
      if (rd_en_b && !prev) bursts++;
      prev = rd_en_b;
      if (mcu_done_b) mds++;
      if (frame_done_b) fds++;
      @(negedge clk);
    end
    checks++;
    if ({bursts, mds, fds} !== {32'd12, 32'd3, 32'd1}) begin
      errors++; $display("FAIL multi_counts: got bursts=%0d mcu=%0d frame=%0d expected 12 3 1", bursts, mds, fds);
    end
  endtask

  task automatic test_async_reset();
    int active;
    active = 0;
    req_b = 3'b111; bb_b = 2'b00; fs_b = 1;
    @(negedge clk);
    fs_b = 0;
    repeat (411) @(negedge clk);
    checks++;
    if ({rd_en_b, busy_b} !== 2'b11) begin
      errors++; $display("FAIL async_pre: got %b expected 11", {rd_en_b, busy_b});
    end
    #2 rst_n_b = 0;
    #1;
    checks++;
    if (obs_b !== 20'd0) begin errors++; $display("FAIL async_reset: got %h expected 0", obs_b); end
    repeat (2) @(negedge clk);
    rst_n_b = 1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (obs_b != 20'd0) active++;
    end
    checks++;
    if (active != 0) begin errors++; $display("FAIL async_after: got %0d active cycles expected 0", active); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_mcu();
    test_order();
    test_backpressure();
    test_abort();
    test_single_mcu();
    test_start_abort();
    test_random();
    test_multi_mcu();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
